// File: rtl/const_load_seq_pkg.sv
// Shared types and constants for the constant-bank load sequencer.
// The optional checksum (macro CONST_LOAD_CHKSUM_EN) is handled in the top.
package const_load_seq_pkg;

    localparam int DATA_W   = 16;
    localparam int ADR_W    = 16;
    localparam int HEAD_W   = 4;
    localparam int ENTRY    = 16;
    localparam int IDX_W    = 4;
    localparam int HEAD_LSB = ADR_W - HEAD_W;

    localparam logic [HEAD_W-1:0] HEAD_CONST = 4'h1;
    localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W:0]    REM_ONE    = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]    LEN_MAX    = (IDX_W + 1)'(ENTRY);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // Global address of a constant entry: head field on top, index at the bottom.
    function automatic logic [ADR_W-1:0] const_adr(input logic [IDX_W-1:0] idx);
        logic [ADR_W-1:0] adr;
        adr                       = '0;
        adr[ADR_W-1:HEAD_LSB]     = HEAD_CONST;
        adr[IDX_W-1:0]            = idx;
        return adr;
    endfunction

endpackage

// File: rtl/const_load_seq_bus_mux.sv
// Host-priority two-input mux with the registered write-bus stage.
// Address and data hold their last values when no write is issued.
module const_bus_mux
    import const_load_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_host_we,
    input  logic [ADR_W-1:0]  i_host_adr,
    input  logic [DATA_W-1:0] i_host_data,
    input  logic              i_s_we,
    input  logic [ADR_W-1:0]  i_s_adr,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_we,
    output logic [ADR_W-1:0]  o_adr,
    output logic [DATA_W-1:0] o_data
);

    logic              we_q, we_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        we_d   = 1'b0;
        adr_d  = adr_q;
        data_d = data_q;
        if (i_host_we) begin
            we_d   = 1'b1;
            adr_d  = i_host_adr;
            data_d = i_host_data;
        end else if (i_s_we) begin
            we_d   = 1'b1;
            adr_d  = i_s_adr;
            data_d = i_s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            adr_q  <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            adr_q  <= adr_d;
            data_q <= data_d;
        end
    end

    assign o_we   = we_q;
    assign o_adr  = adr_q;
    assign o_data = data_q;

endmodule

// File: rtl/const_load_seq.sv
// Burst loader and host arbiter for the constant bank write bus.
// Define CONST_LOAD_CHKSUM_EN to add the o_chksum XOR accumulator output.
module const_load_seq
    import const_load_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_base,
    input  logic [IDX_W:0]    i_len,
    input  logic              i_s_valid,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_s_ready,
    input  logic              i_host_we,
    input  logic [ADR_W-1:0]  i_host_adr,
    input  logic [DATA_W-1:0] i_host_data,
    output logic              o_host_gnt,
    output logic              o_we,
    output logic [ADR_W-1:0]  o_glb_adr,
    output logic [DATA_W-1:0] o_const_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
`ifdef CONST_LOAD_CHKSUM_EN
    output logic [DATA_W-1:0] o_chksum,
`endif
    output logic              o_state_dbg
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   rem_q, rem_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             s_ready;
    logic             s_accept;
    logic             len_ok;
    logic             start_ok;

    assign len_ok   = (i_len != '0) && (i_len <= LEN_MAX);
    assign start_ok = i_start && (state_q == IDLE) && len_ok;

    // Stream handshake: a word transfers on a cycle where i_s_valid and o_s_ready
    // are both high; ready is only offered in LOAD and drops while the host writes.
    assign s_accept = s_ready && i_s_valid;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (len_ok) begin
                        idx_d   = i_base;
                        rem_d   = i_len;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                s_ready = ~i_host_we;
                err_d   = i_start;
                if (s_ready && i_s_valid) begin
                    idx_d = idx_q + IDX_ONE;
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    const_bus_mux u_bus_mux (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_host_we  (i_host_we),
        .i_host_adr (i_host_adr),
        .i_host_data(i_host_data),
        .i_s_we     (s_accept),
        .i_s_adr    (const_adr(idx_q)),
        .i_s_data   (i_s_data),
        .o_we       (o_we),
        .o_adr      (o_glb_adr),
        .o_data     (o_const_data)
    );

`ifdef CONST_LOAD_CHKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (start_ok) begin
            chk_d = '0;
        end else if (s_accept) begin
            chk_d = chk_q ^ i_s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign o_chksum = chk_q;
`endif

    assign o_s_ready   = s_ready;
    assign o_host_gnt  = 1'b1;
    assign o_busy      = (state_q == LOAD);
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_state_dbg = state_q;

endmodule

// File: tb/tb_const_load_seq.sv
// Directed self-checking bench for const_load_seq (checksum checks when
// CONST_LOAD_CHKSUM_EN is defined).
module tb_const_load_seq;
    import const_load_seq_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [IDX_W-1:0]  i_base;
    logic [IDX_W:0]    i_len;
    logic              i_s_valid;
    logic [DATA_W-1:0] i_s_data;
    logic              o_s_ready;
    logic              i_host_we;
    logic [ADR_W-1:0]  i_host_adr;
    logic [DATA_W-1:0] i_host_data;
    logic              o_host_gnt;
    logic              o_we;
    logic [ADR_W-1:0]  o_glb_adr;
    logic [DATA_W-1:0] o_const_data;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_state_dbg;
`ifdef CONST_LOAD_CHKSUM_EN
    logic [DATA_W-1:0] o_chksum;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    const_load_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_len       (i_len),
        .i_s_valid   (i_s_valid),
        .i_s_data    (i_s_data),
        .o_s_ready   (o_s_ready),
        .i_host_we   (i_host_we),
        .i_host_adr  (i_host_adr),
        .i_host_data (i_host_data),
        .o_host_gnt  (o_host_gnt),
        .o_we        (o_we),
        .o_glb_adr   (o_glb_adr),
        .o_const_data(o_const_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
`ifdef CONST_LOAD_CHKSUM_EN
        .o_chksum    (o_chksum),
`endif
        .o_state_dbg (o_state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks one bus write cycle: we, address, data and the done pulse.
    task automatic chk_wr(input string tag, input logic [15:0] adr, input logic [15:0] data,
                          input logic done);
        chk({tag, ".we"}, 32'(o_we), 32'd1);
        chk({tag, ".adr"}, 32'(o_glb_adr), 32'(adr));
        chk({tag, ".data"}, 32'(o_const_data), 32'(data));
        chk({tag, ".done"}, 32'(o_done), 32'(done));
    endtask

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base      = '0;
        i_len       = '0;
        i_s_valid   = 1'b0;
        i_s_data    = '0;
        i_host_we   = 1'b0;
        i_host_adr  = '0;
        i_host_data = '0;

        // Reset state
        #12;
        chk("rst.we", 32'(o_we), 32'd0);
        chk("rst.adr", 32'(o_glb_adr), 32'd0);
        chk("rst.data", 32'(o_const_data), 32'd0);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.done", 32'(o_done), 32'd0);
        chk("rst.err", 32'(o_err), 32'd0);
        chk("rst.ready", 32'(o_s_ready), 32'd0);
        chk("rst.gnt", 32'(o_host_gnt), 32'd1);
        chk("rst.state", 32'(o_state_dbg), 32'd0);
        rst_n = 1'b1;

        // Burst base 4, len 3, back-to-back
        i_start = 1'b1; i_base = 4'd4; i_len = 5'd3;
        tick();
        i_start = 1'b0;
        chk("b1.busy", 32'(o_busy), 32'd1);
        chk("b1.err", 32'(o_err), 32'd0);
        chk("b1.we0", 32'(o_we), 32'd0);
        i_s_valid = 1'b1; i_s_data = 16'h1111;
        #1;
        chk("b1.ready", 32'(o_s_ready), 32'd1);
        tick();
        chk_wr("b1.w0", 16'h1004, 16'h1111, 1'b0);
        i_s_data = 16'h2222;
        tick();
        chk_wr("b1.w1", 16'h1005, 16'h2222, 1'b0);
        i_s_data = 16'h3333;
        tick();
        chk_wr("b1.w2", 16'h1006, 16'h3333, 1'b1);
        chk("b1.busy_end", 32'(o_busy), 32'd0);
        chk("b1.ready_end", 32'(o_s_ready), 32'd0);
        i_s_valid = 1'b0;
        tick();
        chk("b1.we_off", 32'(o_we), 32'd0);
        chk("b1.done_off", 32'(o_done), 32'd0);
        chk("b1.adr_hold", 32'(o_glb_adr), 32'h1006);
        chk("b1.data_hold", 32'(o_const_data), 32'h3333);

        // Wrap-around: base 14, len 4
        i_start = 1'b1; i_base = 4'd14; i_len = 5'd4;
        tick();
        i_start = 1'b0;
        i_s_valid = 1'b1; i_s_data = 16'hA000;
        tick();
        chk_wr("b2.w0", 16'h100E, 16'hA000, 1'b0);
        i_s_data = 16'hA001;
        tick();
        chk_wr("b2.w1", 16'h100F, 16'hA001, 1'b0);
        i_s_data = 16'hA002;
        tick();
        chk_wr("b2.w2", 16'h1000, 16'hA002, 1'b0);
        i_s_data = 16'hA003;
        tick();
        chk_wr("b2.w3", 16'h1001, 16'hA003, 1'b1);
        i_s_valid = 1'b0;
        tick();

        // Host collides with stream valid mid-burst
        i_start = 1'b1; i_base = 4'd0; i_len = 5'd2;
        tick();
        i_start = 1'b0;
        i_s_valid = 1'b1; i_s_data = 16'h5555;
        i_host_we = 1'b1; i_host_adr = 16'h1007; i_host_data = 16'hBEEF;
        #1;
        chk("b3.ready_stall", 32'(o_s_ready), 32'd0);
        tick();
        chk_wr("b3.host", 16'h1007, 16'hBEEF, 1'b0);
        i_host_we = 1'b0;
        #1;
        chk("b3.ready_back", 32'(o_s_ready), 32'd1);
        tick();
        chk_wr("b3.s0", 16'h1000, 16'h5555, 1'b0);
        i_s_data = 16'h6666;
        tick();
        chk_wr("b3.s1", 16'h1001, 16'h6666, 1'b1);
        i_s_valid = 1'b0;
        tick();

        // Host write in IDLE with a foreign head passes through unchanged
        i_host_we = 1'b1; i_host_adr = 16'hABCD; i_host_data = 16'h1234;
        tick();
        i_host_we = 1'b0;
        chk_wr("host.idle", 16'hABCD, 16'h1234, 1'b0);

        // Illegal lengths
        i_start = 1'b1; i_base = 4'd5; i_len = 5'd0;
        tick();
        i_start = 1'b0;
        chk("e0.err", 32'(o_err), 32'd1);
        chk("e0.we", 32'(o_we), 32'd0);
        chk("e0.busy", 32'(o_busy), 32'd0);
        tick();
        chk("e0.err_off", 32'(o_err), 32'd0);
        i_start = 1'b1; i_len = 5'd17;
        tick();
        i_start = 1'b0;
        chk("e17.err", 32'(o_err), 32'd1);
        chk("e17.we", 32'(o_we), 32'd0);
        chk("e17.busy", 32'(o_busy), 32'd0);
        tick();

        // Legal maximum length 16 is accepted
        i_start = 1'b1; i_base = 4'd0; i_len = 5'd16;
        tick();
        i_start = 1'b0;
        chk("l16.busy", 32'(o_busy), 32'd1);
        chk("l16.err", 32'(o_err), 32'd0);
        i_s_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            i_s_data = 16'(k);
            tick();
        end
        chk_wr("l16.w14", 16'h100E, 16'h000E, 1'b0);
        i_s_data = 16'h00FE;
        tick();
        chk_wr("l16.w15", 16'h100F, 16'h00FE, 1'b1);
        i_s_valid = 1'b0;
        tick();

        // Start during LOAD is rejected, burst continues
        i_start = 1'b1; i_base = 4'd2; i_len = 5'd2;
        tick();
        i_base = 4'd9; i_len = 5'd3;
        i_s_valid = 1'b1; i_s_data = 16'h7777;
        tick();
        i_start = 1'b0;
        chk("e.load.err", 32'(o_err), 32'd1);
        chk_wr("e.load.w0", 16'h1002, 16'h7777, 1'b0);
        i_s_data = 16'h8888;
        tick();
        chk("e.load.err_off", 32'(o_err), 32'd0);
        chk_wr("e.load.w1", 16'h1003, 16'h8888, 1'b1);
        i_s_valid = 1'b0;
        tick();

        // Reset mid-burst after 2 of 5 words
        i_start = 1'b1; i_base = 4'd8; i_len = 5'd5;
        tick();
        i_start = 1'b0;
        i_s_valid = 1'b1; i_s_data = 16'hC000;
        tick();
        i_s_data = 16'hC001;
        tick();
        chk_wr("r.w1", 16'h1009, 16'hC001, 1'b0);
        i_s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("r.we", 32'(o_we), 32'd0);
        chk("r.busy", 32'(o_busy), 32'd0);
        chk("r.done", 32'(o_done), 32'd0);
        chk("r.adr", 32'(o_glb_adr), 32'd0);
        chk("r.ready", 32'(o_s_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("r.done_after", 32'(o_done), 32'd0);
        chk("r.busy_after", 32'(o_busy), 32'd0);
        i_start = 1'b1; i_base = 4'd3; i_len = 5'd1;
        tick();
        i_start = 1'b0;
        i_s_valid = 1'b1; i_s_data = 16'h9999;
        tick();
        chk_wr("r.new", 16'h1003, 16'h9999, 1'b1);
        i_s_valid = 1'b0;
        tick();

`ifdef CONST_LOAD_CHKSUM_EN
        // Checksum with an interleaved host write
        i_start = 1'b1; i_base = 4'd0; i_len = 5'd3;
        tick();
        i_start = 1'b0;
        chk("cs.clear", 32'(o_chksum), 32'd0);
        i_s_valid = 1'b1; i_s_data = 16'h00FF;
        tick();
        i_host_we = 1'b1; i_host_adr = 16'h1005; i_host_data = 16'hFFFF;
        i_s_data = 16'h0F0F;
        tick();
        i_host_we = 1'b0;
        tick();
        i_s_data = 16'hF000;
        tick();
        chk_wr("cs.last", 16'h1002, 16'hF000, 1'b1);
        chk("cs.sum", 32'(o_chksum), 32'hFFF0);
        i_s_valid = 1'b0;
        tick();
        chk("cs.hold", 32'(o_chksum), 32'hFFF0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/const_load_seq.md
Name: const_load_seq

Overview:
- Sequencer and arbiter in front of the constant register bank's global write bus (we / glb_adr / data).
- Burst-loads a run of constants from a valid/ready word stream into consecutive bank entries, starting from a commanded base index with wrap-around.
- Shares the write bus with direct host writes; the host always has priority.
- All bus outputs are registered and feed the constant bank's external write port.

Parameters:
- DATA_W, 16, constant word width.
- ADR_W, 16, global address width.
- HEAD_W, 4, width of the address head field, located at bits [ADR_W-1 : ADR_W-HEAD_W].
- HEAD_CONST, 4'h1, head value that selects the constant bank.
- ENTRY, 16, number of constant entries.
- IDX_W, 4, entry index width; log2(ENTRY).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle load command
- i_base  in  IDX_W  first entry index of the burst
- i_len  in  IDX_W+1  number of words to load; legal range 1..ENTRY
- i_s_valid  in  1  stream word valid
- i_s_data  in  DATA_W  stream word
- o_s_ready  out  1  stream word accepted when i_s_valid & o_s_ready
- i_host_we  in  1  host write request (single cycle)
- i_host_adr  in  ADR_W  host global address
- i_host_data  in  DATA_W  host write data
- o_host_gnt  out  1  always 1; host writes are never refused
- o_we  out  1  registered write enable to the bank
- o_glb_adr  out  ADR_W  registered address
- o_const_data  out  DATA_W  registered data
- o_busy  out  1  high in LOAD
- o_done  out  1  one-cycle pulse when the last word has been issued on the bus
- o_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset: FSM to IDLE. o_we, o_glb_adr, o_const_data, o_busy, o_done, o_err and the internal counters all go to 0. o_s_ready goes to 0. o_host_gnt is 1.
- IDLE state:
  - o_s_ready = 0.
  - i_start with 1 <= i_len <= ENTRY: latch idx = i_base and rem = i_len, then go to LOAD.
  - i_start with i_len = 0 or i_len > ENTRY: pulse o_err next cycle and stay in IDLE.
- LOAD state:
  - o_busy = 1.
  - o_s_ready = ~i_host_we (combinational stall while the host writes).
  - On an accepted beat: next cycle drive o_we = 1, o_glb_adr = {HEAD_CONST, zero padding, idx}, o_const_data = word.
  - After each accepted beat: idx = (idx + 1) mod ENTRY, rem = rem - 1.
  - When the beat accepted with rem = 1 is issued, pulse o_done in the same cycle as its o_we and go to IDLE.
  - i_start while in LOAD: ignored, with an o_err pulse.
- Host path (any state): i_host_we causes, next cycle, o_we = 1 with o_glb_adr = i_host_adr and o_const_data = i_host_data, passed through unmodified (any head value).
- Simultaneous host write and stream valid: the host write is issued; the stream beat is not accepted because o_s_ready = 0; at most one bus write per cycle.
- Bus outputs with no write that cycle: o_we = 0; o_glb_adr and o_const_data hold their last values.
- Latency: one cycle from acceptance (host or stream) to o_we.
- Back-to-back throughput: one write per cycle.
- Reset mid-LOAD: the burst is abandoned, no o_done, outputs return to reset values immediately.

Optional Feature:
- Macro: CONST_LOAD_CHKSUM_EN.
- When defined:
  - Adds output o_chksum (DATA_W).
  - o_chksum is cleared on an accepted i_start and XOR-accumulates every accepted stream word; host words are excluded.
  - It is valid when o_done pulses and holds until the next accepted start.
  - Reset value is 0.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE = 0, LOAD = 1).
  - HEAD_CONST and head field position.
  - ENTRY, IDX_W, DATA_W, ADR_W.
- Optional sub-module const_bus_mux: two-input priority mux plus output register stage for we/adr/data. The FSM stays in the top.

Test Plan:
- Start, base = 4, len = 3; stream 0x1111, 0x2222, 0x3333 back-to-back -> o_we on 3 consecutive cycles at indices 4, 5, 6 with head 0x1; o_done coincides with the index-6 write; o_busy falls after it.
- Base = 14, len = 4 -> writes to indices 14, 15, 0, 1 (wrap-around).
- During a burst, assert i_host_we with adr 0x1007, data 0xBEEF in the same cycle as stream valid -> host write issued first with o_s_ready = 0; stream word issued the following cycle; no data lost; write order is host then stream.
- Start with len = 0, and start with len = 17 -> o_err pulse each time, no o_we, stays IDLE; i_start during LOAD -> o_err, burst unaffected.
- Assert rst_n low mid-burst after 2 of 5 words -> o_we / o_busy = 0 immediately, no o_done; a new start then works normally.
- With CONST_LOAD_CHKSUM_EN: stream 0x00FF, 0x0F0F, 0xF000 -> o_chksum = 0xFFF0 at o_done; an interleaved host write does not change it.
